// File: rtl/lcd_pkg.sv
// Shared constants, types and address helpers for the HD44780-compatible bus responder.
package lcd_pkg;

    localparam int         DDRAM_DEPTH = 80;
    localparam logic [7:0] FILL_CHAR   = 8'h20;
    localparam logic [7:0] LINE0_BASE  = 8'h00;
    localparam logic [7:0] LINE1_BASE  = 8'h40;
    localparam int         LINE_LEN    = 40;

    localparam logic [7:0] PFX_DDRAM = 8'h80;
    localparam logic [7:0] PFX_CGRAM = 8'h40;
    localparam logic [7:0] PFX_FUNC  = 8'h20;
    localparam logic [7:0] PFX_SHIFT = 8'h10;
    localparam logic [7:0] PFX_DISP  = 8'h08;
    localparam logic [7:0] PFX_ENTRY = 8'h04;
    localparam logic [7:0] PFX_HOME  = 8'h02;
    localparam logic [7:0] PFX_CLEAR = 8'h01;

    typedef enum logic [3:0] {
        OP_NOP, OP_DDRAM, OP_CGRAM, OP_FUNC, OP_SHIFT,
        OP_DISP, OP_ENTRY, OP_HOME, OP_CLEAR
    } lcd_op_e;

    typedef struct packed {
        logic display_on;
        logic cursor_on;
        logic blink_on;
        logic lines_2;
        logic font_5x10;
        logic inc;
    } lcd_flags_t;

    // Highest set bit selects the instruction.
    function automatic lcd_op_e decode_op(input logic [7:0] c);
        if ((c & PFX_DDRAM) != 8'h00) return OP_DDRAM;
        if ((c & PFX_CGRAM) != 8'h00) return OP_CGRAM;
        if ((c & PFX_FUNC)  != 8'h00) return OP_FUNC;
        if ((c & PFX_SHIFT) != 8'h00) return OP_SHIFT;
        if ((c & PFX_DISP)  != 8'h00) return OP_DISP;
        if ((c & PFX_ENTRY) != 8'h00) return OP_ENTRY;
        if ((c & PFX_HOME)  != 8'h00) return OP_HOME;
        if ((c & PFX_CLEAR) != 8'h00) return OP_CLEAR;
        return OP_NOP;
    endfunction

    function automatic logic [6:0] addr_to_linear(input logic [6:0] ac, input logic lines_2);
        if (lines_2 && ac >= LINE1_BASE[6:0])
            return ac - LINE1_BASE[6:0] + 7'(LINE_LEN);
        return ac;
    endfunction

    function automatic logic ddram_addr_ok(input logic [6:0] a, input logic lines_2);
        if (!lines_2)
            return a < 7'(DDRAM_DEPTH);
        return (a < LINE0_BASE[6:0] + 7'(LINE_LEN)) ||
               (a >= LINE1_BASE[6:0] && a < LINE1_BASE[6:0] + 7'(LINE_LEN));
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                           input logic lines_2);
        logic [6:0] l0, l1, l0_end, l1_end;
        l0     = LINE0_BASE[6:0];
        l1     = LINE1_BASE[6:0];
        l0_end = l0 + 7'(LINE_LEN - 1);
        l1_end = l1 + 7'(LINE_LEN - 1);
        if (!lines_2) begin
            if (inc) return (ac == 7'(DDRAM_DEPTH - 1)) ? 7'd0 : ac + 7'd1;
            return (ac == 7'd0) ? 7'(DDRAM_DEPTH - 1) : ac - 7'd1;
        end
        if (inc) begin
            if (ac == l0_end) return l1;
            if (ac == l1_end) return l0;
            return ac + 7'd1;
        end
        if (ac == l1) return l0_end;
        if (ac == l0) return l1_end;
        return ac - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one synchronous write port, one registered read port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [6:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [0:DDRAM_DEPTH-1];
    logic [7:0] r_rdata;

    // Read-before-write: a same-index read returns the previous contents.
    always_ff @(posedge clk) begin
        if (i_we && i_waddr < 7'(DDRAM_DEPTH))
            r_mem[i_waddr] <= i_wdata;
        if (i_raddr < 7'(DDRAM_DEPTH))
            r_rdata <= r_mem[i_raddr];
        else
            r_rdata <= FILL_CHAR;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_responder.sv
// Display-side HD44780 bus responder: samples RS/E/D, executes on E fall, keeps
// AC, flags and DDRAM, and sweeps DDRAM with FILL_CHAR on clear or reset.
module lcd_responder
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RS,
    input  logic       E,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    input  logic       D4,
    input  logic       D5,
    input  logic       D6,
    input  logic       D7,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       lines_2,
    output logic       font_5x10,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_code,
    output logic       cmd_err
);

    localparam logic [6:0] LAST_IDX = 7'(DDRAM_DEPTH - 1);

    logic       r_e_q, r_e_qq, r_rs_q, r_lat_rs, r_exec;
    logic [7:0] r_d_q, r_lat_d;
    logic       r_busy;
    logic [6:0] r_sweep_idx;
    logic [6:0] r_ac;
    lcd_flags_t r_flags;
    logic       r_cg_mode;
    logic       r_cmd_valid, r_cmd_err, r_cmd_rs;
    logic [7:0] r_cmd_code;

    logic       w_rise, w_fall;
    lcd_op_e    w_op;
    logic [6:0] w_lin;
    logic [6:0] w_ac_nxt;
    lcd_flags_t w_flags_nxt;
    logic       w_cg_nxt, w_ok, w_err, w_clear, w_data_we;
    logic       w_mem_we;
    logic [6:0] w_mem_addr;
    logic [7:0] w_mem_data;

    assign w_rise = r_e_q & ~r_e_qq;
    assign w_fall = ~r_e_q & r_e_qq;

    // Pin sampler; the fall is registered once more so execution lands two edges later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_e_q    <= 1'b0;
            r_e_qq   <= 1'b0;
            r_rs_q   <= 1'b0;
            r_d_q    <= 8'h00;
            r_lat_rs <= 1'b0;
            r_lat_d  <= 8'h00;
            r_exec   <= 1'b0;
        end else begin
            r_e_q  <= E;
            r_e_qq <= r_e_q;
            r_rs_q <= RS;
            r_d_q  <= {D7, D6, D5, D4, D3, D2, D1, D0};
            if (w_rise) begin
                r_lat_rs <= r_rs_q;
                r_lat_d  <= r_d_q;
            end
            r_exec <= w_fall;
        end
    end

    assign w_op  = decode_op(r_lat_d);
    assign w_lin = addr_to_linear(r_ac, r_flags.lines_2);

    always_comb begin
        w_ac_nxt    = r_ac;
        w_flags_nxt = r_flags;
        w_cg_nxt    = r_cg_mode;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_clear     = 1'b0;
        w_data_we   = 1'b0;
        if (r_exec) begin
            if (r_busy) begin
                w_err = 1'b1;
            end else if (r_lat_rs) begin
                w_ok = 1'b1;
                // Data aimed at CGRAM is swallowed without touching AC.
                if (!r_cg_mode) begin
                    w_data_we = 1'b1;
                    w_ac_nxt  = ac_step(r_ac, r_flags.inc, r_flags.lines_2);
                end
            end else begin
                w_ok = 1'b1;
                case (w_op)
                    OP_DDRAM: begin
                        if (ddram_addr_ok(r_lat_d[6:0], r_flags.lines_2)) begin
                            w_ac_nxt = r_lat_d[6:0];
                            w_cg_nxt = 1'b0;
                        end else begin
                            w_ok  = 1'b0;
                            w_err = 1'b1;
                        end
                    end
                    OP_CGRAM: w_cg_nxt = 1'b1;
                    OP_FUNC: begin
                        w_flags_nxt.lines_2   = r_lat_d[3];
                        w_flags_nxt.font_5x10 = r_lat_d[2];
                    end
                    OP_SHIFT: begin
                        if (!r_lat_d[3])
                            w_ac_nxt = ac_step(r_ac, r_lat_d[2], r_flags.lines_2);
                    end
                    OP_DISP: begin
                        w_flags_nxt.display_on = r_lat_d[2];
                        w_flags_nxt.cursor_on  = r_lat_d[1];
                        w_flags_nxt.blink_on   = r_lat_d[0];
                    end
                    OP_ENTRY: w_flags_nxt.inc = r_lat_d[1];
                    OP_HOME:  w_ac_nxt = 7'd0;
                    OP_CLEAR: begin
                        w_ac_nxt        = 7'd0;
                        w_flags_nxt.inc = 1'b1;
                        w_clear         = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ac        <= 7'd0;
            r_flags     <= '{inc: 1'b1, default: 1'b0};
            r_cg_mode   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_rs    <= 1'b0;
            r_cmd_code  <= 8'h00;
        end else begin
            r_ac        <= w_ac_nxt;
            r_flags     <= w_flags_nxt;
            r_cg_mode   <= w_cg_nxt;
            r_cmd_valid <= w_ok;
            r_cmd_err   <= w_err;
            if (w_ok) begin
                r_cmd_rs   <= r_lat_rs;
                r_cmd_code <= r_lat_d;
            end
        end
    end

    // Sweep: one FILL_CHAR write per cycle, busy drops with the write of the last index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy      <= 1'b1;
            r_sweep_idx <= 7'd0;
        end else if (r_busy) begin
            r_sweep_idx <= (r_sweep_idx == LAST_IDX) ? 7'd0 : r_sweep_idx + 7'd1;
            if (r_sweep_idx == LAST_IDX)
                r_busy <= 1'b0;
        end else if (w_clear) begin
            r_busy      <= 1'b1;
            r_sweep_idx <= 7'd0;
        end
    end

    assign w_mem_we   = rst_n & (r_busy | w_data_we);
    assign w_mem_addr = r_busy ? r_sweep_idx : w_lin;
    assign w_mem_data = r_busy ? FILL_CHAR : r_lat_d;

    lcd_ddram u_ddram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_addr),
        .i_wdata (w_mem_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign busy        = r_busy;
    assign cursor_addr = r_ac;
    assign display_on  = r_flags.display_on;
    assign cursor_on   = r_flags.cursor_on;
    assign blink_on    = r_flags.blink_on;
    assign lines_2     = r_flags.lines_2;
    assign font_5x10   = r_flags.font_5x10;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_err     = r_cmd_err;
    assign cmd_rs      = r_cmd_rs;
    assign cmd_code    = r_cmd_code;

endmodule

// File: tb/tb_lcd_responder.sv
// Randomized bench for lcd_responder against a linear-address reference model.
module tb_lcd_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_rs = 1'b0, bus_e = 1'b0;
    logic [7:0] bus_d = 8'h00;
    logic [6:0] rd_addr = 7'd0;
    logic [7:0] rd_data;
    logic       busy, display_on, cursor_on, blink_on, lines_2, font_5x10;
    logic       cmd_valid, cmd_rs, cmd_err;
    logic [6:0] cursor_addr;
    logic [7:0] cmd_code;

    int n_cmp = 0, n_bad = 0, cyc = 0, n_valid = 0;

    // Reference model state
    logic [7:0] m_mem [80];
    int         m_ac, m_clear_edge;
    logic       m_d, m_c, m_b, m_n, m_f, m_id, m_cg;

    lcd_responder dut (
        .clk(clk), .rst_n(rst_n), .RS(bus_rs), .E(bus_e),
        .D0(bus_d[0]), .D1(bus_d[1]), .D2(bus_d[2]), .D3(bus_d[3]),
        .D4(bus_d[4]), .D5(bus_d[5]), .D6(bus_d[6]), .D7(bus_d[7]),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .cursor_addr(cursor_addr),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .lines_2(lines_2), .font_5x10(font_5x10), .cmd_valid(cmd_valid),
        .cmd_rs(cmd_rs), .cmd_code(cmd_code), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cmd_valid === 1'b1) n_valid <= n_valid + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Display positions as 0..79 in reading order; AC is just a label for a position.
    function automatic int m_lin(input int ac);
        return (m_n && ac >= 64) ? ac - 24 : ac;
    endfunction

    function automatic int m_unlin(input int pos);
        return (m_n && pos >= 40) ? pos + 24 : pos;
    endfunction

    function automatic int m_step(input int ac, input logic inc);
        return m_unlin((m_lin(ac) + (inc ? 1 : 79)) % 80);
    endfunction

    function automatic logic m_valid(input int a);
        return m_n ? (a < 40 || (a >= 64 && a < 104)) : (a < 80);
    endfunction

    task automatic m_fill();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    endtask

    task automatic m_reset();
        m_ac = 0; m_d = 0; m_c = 0; m_b = 0; m_n = 0; m_f = 0; m_id = 1; m_cg = 0;
        m_fill();
    endtask

    task automatic m_exec(input logic rs, input logic [7:0] d, input int y,
                          output logic ok, output logic err);
        ok = 1'b1; err = 1'b0;
        if (y <= m_clear_edge + 80) begin
            ok = 1'b0; err = 1'b1;
        end else if (rs) begin
            if (!m_cg) begin
                if (m_lin(m_ac) < 80) m_mem[m_lin(m_ac)] = d;
                m_ac = m_step(m_ac, m_id);
            end
        end else if (d[7]) begin
            if (m_valid(int'(d[6:0]))) begin m_ac = int'(d[6:0]); m_cg = 0; end
            else begin ok = 1'b0; err = 1'b1; end
        end else if (d[6]) m_cg = 1;
        else if (d[5]) begin m_n = d[3]; m_f = d[2]; end
        else if (d[4]) begin if (!d[3]) m_ac = m_step(m_ac, d[2]); end
        else if (d[3]) begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
        else if (d[2]) m_id = d[1];
        else if (d[1]) m_ac = 0;
        else if (d[0]) begin m_ac = 0; m_id = 1; m_clear_edge = y; m_fill(); end
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        logic ok, err;
        @(negedge clk); bus_rs = rs; bus_d = d; bus_e = 1'b1;
        repeat (2) @(negedge clk);
        bus_e = 1'b0;
        repeat (2) @(negedge clk);
        chk("early_pulse", {cmd_valid, cmd_err}, 2'b00);
        @(negedge clk);
        m_exec(rs, d, cyc, ok, err);
        chk("cmd_valid", cmd_valid, ok);
        chk("cmd_err", cmd_err, err);
        chk("cursor_addr", cursor_addr, m_ac);
        chk("flags", {display_on, cursor_on, blink_on, lines_2, font_5x10},
            {m_d, m_c, m_b, m_n, m_f});
        if (ok) chk("cmd_code", {cmd_rs, cmd_code}, {rs, d});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic rd(input int idx, output logic [7:0] v);
        @(negedge clk); rd_addr = 7'(idx);
        @(negedge clk); v = rd_data;
    endtask

    task automatic check_str(input int base, input string s);
        logic [7:0] v;
        for (int i = 0; i < s.len(); i++) begin
            rd(base + i, v);
            chk($sformatf("ddram[%0d]", base + i), v, s[i]);
        end
    endtask

    task automatic count_busy();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 200);
        chk("busy_len", n, 80);
    endtask

    task automatic release_reset();
        chk("rst_outputs", {cursor_addr, display_on, cursor_on, blink_on, lines_2, font_5x10,
                            cmd_valid, cmd_rs, cmd_code, cmd_err}, 0);
        chk("rst_busy", busy, 1);
        rst_n = 1'b1;
        m_reset();
        m_clear_edge = cyc;
    endtask

    initial begin
        logic [7:0] v, d;
        int nv0, r;

        // Reset and the power-on sweep
        repeat (3) @(negedge clk);
        release_reset();
        count_busy();
        rd(0, v);  chk("fill0", v, 8'h20);
        rd(39, v); chk("fill39", v, 8'h20);
        rd(79, v); chk("fill79", v, 8'h20);

        // Typical writer init and first line
        nv0 = n_valid;
        send(0, 8'h3C); send(0, 8'h01); wait_idle();
        send(0, 8'h02); send(0, 8'h0C); send(0, 8'h80);
        send(1, "B"); send(1, "a"); send(1, "s"); send(1, "e"); send(1, ":");
        @(negedge clk);
        chk("valid_pulses", n_valid - nv0, 10);
        chk("init_lines2", lines_2, 1);
        chk("init_disp", {display_on, cursor_on}, 2'b10);
        chk("init_ac", cursor_addr, 7'h05);
        check_str(0, "Base:");

        send(0, 8'hC0);
        send(1, "E"); send(1, "n"); send(1, "c"); send(1, "r"); send(1, ":");
        chk("line2_ac", cursor_addr, 7'h45);
        send(0, 8'h94);
        send(1, "D"); send(1, "e"); send(1, "c"); send(1, "r"); send(1, ":");
        check_str(40, "Encr:");
        check_str(20, "Decr:");

        // Line wrap forwards, then backwards past 0x00
        send(0, 8'hA7); send(1, 8'h41);
        chk("wrap_fwd_ac", cursor_addr, 7'h40);
        rd(39, v); chk("wrap_fwd_data", v, 8'h41);
        send(0, 8'h04); send(0, 8'h80); send(1, 8'h42);
        chk("wrap_bwd_ac", cursor_addr, 7'h67);
        rd(0, v); chk("wrap_bwd_data", v, 8'h42);

        // Write during clear is dropped
        send(0, 8'h01);
        repeat (10) @(negedge clk);
        send(1, 8'h58);
        chk("busy_drop_err", cmd_err, 1);
        wait_idle();
        rd(0, v); chk("busy_drop_data", v, 8'h20);

        // Address outside the two-line map
        send(0, 8'hA8);
        chk("bad_addr_err", cmd_err, 1);
        chk("bad_addr_ac", cursor_addr, 7'h00);

        // Single-line mode wrap at 0x4F
        send(0, 8'h30); send(0, 8'hCF); send(1, 8'h5A);
        chk("one_line_wrap", cursor_addr, 7'h00);
        rd(79, v); chk("one_line_data", v, 8'h5A);
        send(0, 8'h3C);

        // Random traffic, kept in two-line mode
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      send(1, 8'($urandom_range(33, 126)));
            else begin
                if (r < 53)      d = 8'h80 | 8'($urandom_range(0, 127));
                else if (r < 57) d = 8'h40 | 8'($urandom_range(0, 63));
                else if (r < 63) d = 8'h28 | (8'($urandom) & 8'h17);
                else if (r < 71) d = 8'h10 | 8'($urandom_range(0, 15));
                else if (r < 79) d = 8'h08 | 8'($urandom_range(0, 7));
                else if (r < 87) d = 8'h04 | 8'($urandom_range(0, 3));
                else if (r < 91) d = 8'h02 | 8'($urandom_range(0, 1));
                else if (r < 94) d = 8'h00;
                else             d = 8'h01;
                send(0, d);
                if (d == 8'h01 && $urandom_range(0, 1) == 1) wait_idle();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        for (int i = 0; i < 80; i++) begin
            rd(i, v);
            chk($sformatf("final_ddram[%0d]", i), v, m_mem[i]);
        end

        // Reset during a sweep restarts it
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        release_reset();
        count_busy();
        rd(50, v); chk("restart_fill", v, 8'h20);
        rd(0, v);  chk("restart_fill0", v, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
